vc_test_rand_delay_src: RTL and testbench

//  Test source: replays a preloaded message table onto a val/rdy output.

---
 rtl/vc_test_rand_delay_src.sv | 139 +++++++++++++
 tb/tb_vc_test_rand_delay_src.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_test_rand_delay_src.sv
// Test source: replays a preloaded message table on val/rdy with seeded pseudo-random idle gaps.
// Latency: first val one cycle after reset release; each gap is 0..max_delay idle cycles.
// Backpressure: val/msg/idx hold while rdy is low; the LFSR steps only on an accepted message.
// Optional VC_TEST_RAND_DELAY_SRC_TRACE_EN compiles in simulation line tracing and a num_msgs check.
module vc_test_rand_delay_src #(
    parameter int unsigned p_msg_nbits = 1,
    parameter int unsigned p_num_msgs  = 1024,
    parameter logic [15:0] p_seed      = 16'hACE1,
    localparam int unsigned AW         = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            max_delay,
    input  logic [31:0]            num_msgs,
    input  logic                   mem_wen,
    input  logic [AW-1:0]          mem_addr,
    input  logic [p_msg_nbits-1:0] mem_wdata,
    output logic                   val,
    input  logic                   rdy,
    output logic [p_msg_nbits-1:0] msg,
    output logic                   done
);

    // An all-zero Galois LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED = (p_seed == 16'h0000) ? 16'h0001 : p_seed;

    typedef enum logic [1:0] {
        DELAY = 2'd0,
        SEND  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [AW:0]      idx, idx_n;
    logic [31:0]      dly_cnt, dly_n;
    logic [15:0]      lfsr, lfsr_n, lfsr_adv;
    logic [32:0]      gap;
    logic [p_msg_nbits-1:0] mem [p_num_msgs];

    // Galois right-shift form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    assign lfsr_adv = lfsr_step(lfsr);
    // 33-bit divisor keeps max_delay=0xFFFFFFFF from wrapping to a zero modulus.
    assign gap      = 33'(lfsr_adv) % (33'(max_delay) + 33'd1);

    assign val  = (state == SEND);
    assign done = (state == DONE);
    assign msg  = mem[idx[AW-1:0]];

    // Table write port; contents deliberately survive reset so a rerun replays the same data.
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= DELAY;
            idx     <= '0;
            dly_cnt <= '0;
            lfsr    <= SEED;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            dly_cnt <= dly_n;
            lfsr    <= lfsr_n;
        end
    end

    // Next-state: count down the gap, present a message until accepted, then pick the next gap.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        dly_n   = dly_cnt;
        lfsr_n  = lfsr;
        case (state)
            DELAY: begin
                if (dly_cnt != 32'd0) begin
                    dly_n = dly_cnt - 32'd1;
                end else if (32'(idx) == num_msgs) begin
                    state_n = DONE;
                end else begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (rdy) begin
                    idx_n  = idx + 1'b1;
                    lfsr_n = lfsr_adv;
                    if (32'(idx) + 32'd1 == num_msgs) begin
                        state_n = DONE;
                    end else if (gap == 33'd0) begin
                        state_n = SEND;
                    end else begin
                        state_n = DELAY;
                        dly_n   = 32'(gap - 33'd1);
                    end
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = DELAY;
            end
        endcase
    end

`ifdef VC_TEST_RAND_DELAY_SRC_TRACE_EN
    logic reset_q;

    // Simulation-only line trace and table-depth sanity check at reset release.
    always @(posedge clk) begin
        reset_q <= reset;
        if (reset && !reset_q && (num_msgs > 32'(p_num_msgs))) begin
            $error("vc_test_rand_delay_src: num_msgs %0d exceeds table depth %0d", num_msgs, p_num_msgs);
        end
        if (reset) begin
            if (val && rdy) begin
                $write("%h", msg);
            end else if (val) begin
                $write("#");
            end else if (done) begin
                $write("  ");
            end else begin
                $write(".");
            end
        end
    end
`else
    // Trace disabled: no simulation-only code is compiled.
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_src.sv
module tb_vc_test_rand_delay_src;

    localparam int unsigned MW = 8;
    localparam int unsigned NM = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   max_delay;
    logic [31:0]   num_msgs;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wdata;
    logic          val;
    logic          rdy;
    logic [MW-1:0] msg;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [MW-1:0] exp_msg [NM];
    logic [31:0]   exp_gap [NM];

    vc_test_rand_delay_src #(
        .p_msg_nbits (MW),
        .p_num_msgs  (NM),
        .p_seed      (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .max_delay (max_delay),
        .num_msgs  (num_msgs),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Edge, then settle: observed values are those of the following cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-bit Galois LFSR: feedback bit lands in 15 and is XORed into 13, 12, 10.
    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] r;
        logic        fb;
        fb    = s[0];
        r     = {1'b0, s[15:1]};
        r[15] = fb;
        r[13] = s[14] ^ fb;
        r[12] = s[13] ^ fb;
        r[10] = s[11] ^ fb;
        return r;
    endfunction

    task automatic build_gaps(input logic [31:0] maxd, input int n);
        logic [15:0] s;
        s = 16'hACE1;
        exp_gap[0] = 32'd0;
        for (int k = 1; k < n; k++) begin
            s = model_step(s);
            exp_gap[k] = 32'(33'(s) % (33'(maxd) + 33'd1));
        end
    endtask

    task automatic load_table(input int n);
        for (int i = 0; i < n; i++) begin
            mem_wen   = 1'b1;
            mem_addr  = AW'(i);
            mem_wdata = exp_msg[i];
            tick();
        end
        mem_wen = 1'b0;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        tick();
        tick();
    endtask

    // Release reset and consume messages with rdy=1, checking data and idle gap of each.
    task automatic run_stream(input string tag, input int n, input int stop_after, input int budget);
        int got;
        int idle;
        int cyc;
        got  = 0;
        idle = 0;
        cyc  = 0;
        rdy  = 1'b1;
        reset = 1'b1;
        tick();
        while (got < stop_after && cyc < budget) begin
            if (val) begin
                check($sformatf("%s msg%0d", tag, got), 64'(msg), 64'(exp_msg[got]));
                check($sformatf("%s gap%0d", tag, got), 64'(idle), 64'(exp_gap[got]));
                got++;
                idle = 0;
            end else begin
                idle++;
            end
            tick();
            cyc++;
        end
        check($sformatf("%s count", tag), 64'(got), 64'(stop_after));
        if (stop_after == n) begin
            check($sformatf("%s done", tag), 64'(done), 64'd1);
            check($sformatf("%s val_after_done", tag), 64'(val), 64'd0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        max_delay = 32'd0;
        num_msgs  = 32'd4;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rdy       = 1'b1;
        for (int i = 0; i < NM; i++) begin
            exp_msg[i] = MW'(17 * (i + 1));
        end

        // Reset state
        hold_reset();
        check("reset val", 64'(val), 64'd0);
        check("reset done", 64'(done), 64'd0);
        load_table(NM);
        check("reset val during load", 64'(val), 64'd0);

        // Test 1: back-to-back, val on cycles 1-4, done from cycle 5
        max_delay = 32'd0;
        num_msgs  = 32'd4;
        build_gaps(32'd0, 4);
        hold_reset();
        run_stream("t1", 4, 4, 20);

        // Test 2: rdy low cycles 1-5, message held without retraction
        hold_reset();
        rdy   = 1'b0;
        reset = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t2 val c%0d", c), 64'(val), 64'd1);
            check($sformatf("t2 msg c%0d", c), 64'(msg), 64'h11);
            tick();
        end
        rdy = 1'b1;
        check("t2 msg c6", 64'(msg), 64'h11);
        tick();
        check("t2 msg c7", 64'(msg), 64'h22);
        tick();
        check("t2 msg c8", 64'(msg), 64'h33);
        tick();
        check("t2 msg c9", 64'(msg), 64'h44);
        check("t2 done c9", 64'(done), 64'd0);
        tick();
        check("t2 done c10", 64'(done), 64'd1);
        check("t2 val c10", 64'(val), 64'd0);

        // Test 4: zero messages goes straight to done
        num_msgs = 32'd0;
        hold_reset();
        reset = 1'b1;
        tick();
        check("t4 done c1", 64'(done), 64'd1);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("t4 val c%0d", c), 64'(val), 64'd0);
            tick();
        end

        // Test 3: max_delay=3, 16 messages, gaps from the LFSR model
        max_delay = 32'd3;
        num_msgs  = 32'd16;
        build_gaps(32'd3, 16);
        hold_reset();
        run_stream("t3", 16, 16, 300);

        // Test 5: one-cycle reset after two accepts, replay must be identical
        hold_reset();
        run_stream("t5a", 16, 2, 100);
        reset = 1'b0;
        tick();
        check("t5 val in reset", 64'(val), 64'd0);
        check("t5 done in reset", 64'(done), 64'd0);
        run_stream("t5b", 16, 16, 300);

        // Test 6: max_delay=0xFFFFFFFF, gap equals first LFSR step 0xE270
        max_delay  = 32'hFFFF_FFFF;
        num_msgs   = 32'd2;
        exp_gap[0] = 32'd0;
        exp_gap[1] = 32'h0000_E270;
        hold_reset();
        run_stream("t6", 2, 2, 60000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
